// File: rtl/if_prefetch_stage_pkg.sv
// if_prefetch_stage_pkg
//   Shared definitions for the instruction-fetch prefetch stage: default
//   address/instruction width, sequential PC increment, reset PC, the queue
//   entry layout and the NOP word driven when nothing is valid.
package if_prefetch_stage_pkg;

  localparam int unsigned IF_WIDTH    = 32;
  localparam int unsigned IF_PC_STEP  = 4;
  localparam logic [IF_WIDTH-1:0] IF_RESET_PC = '0;
  localparam logic [IF_WIDTH-1:0] IF_NOP      = '0;

  // One queue entry at the default width: next-sequential PC plus instruction.
  typedef struct packed {
    logic [IF_WIDTH-1:0] pc;
    logic [IF_WIDTH-1:0] instr;
  } if_entry_t;

endpackage

// File: rtl/if_prefetch_stage_if.sv
// if_prefetch_stage_if
//   Instruction-memory port bundle.
//   imem_addr  : fetch address (fetch side -> memory)
//   imem_rdata : read data for imem_addr, combinational (memory -> fetch side)
//   imem_ready : imem_rdata valid this cycle (memory -> fetch side)
//   Modports: master = fetch stage, slave = instruction memory.
interface if_prefetch_stage_if
  import if_prefetch_stage_pkg::*;
#(
  parameter int unsigned WIDTH = IF_WIDTH
);
  logic [WIDTH-1:0] imem_addr;
  logic [WIDTH-1:0] imem_rdata;
  logic             imem_ready;

  modport master (output imem_addr, input imem_rdata, input imem_ready);
  modport slave  (input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/if_prefetch_stage_fifo.sv
// if_prefetch_fifo
//   Circular buffer of DEPTH entries, DW bits each.
//   clk, rst    : clock, synchronous active-high reset
//   clear       : discard all entries (dominates push/pop)
//   push, wdata : write wdata at tail (accepted when not full or popping)
//   pop         : drop head entry (ignored when empty)
//   rdata       : head entry contents (unspecified when empty)
//   count       : occupancy 0..DEPTH; full/empty derived from it
module if_prefetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 64,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [DW-1:0]    wdata,
  output logic [DW-1:0]    rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[head];

  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[tail] <= wdata;
        tail      <= tail + 1'b1;
      end
      if (do_pop) begin
        head <= head + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage
//   Instruction-fetch stage with a DEPTH-entry prefetch queue feeding IF/ID.
//   clk, rst        : clock, synchronous active-high reset
//   freeze          : decode stalled, head entry not consumed
//   Branch_taken    : redirect fetch to branchAddr and discard the queue
//   branchAddr      : redirect target
//   imem (master)   : imem_addr out, imem_rdata/imem_ready in
//   valid           : head entry present
//   PC              : head entry fetch address + PC_STEP (0 when empty)
//   Instruction     : head entry instruction (NOP when empty)
//   count           : queue occupancy
//   Optional (IF_PREFETCH_PERF_EN): perf_delivered, perf_discarded counters.
module if_prefetch_stage
  import if_prefetch_stage_pkg::*;
#(
  parameter int unsigned WIDTH   = IF_WIDTH,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PC_STEP = IF_PC_STEP,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(IF_RESET_PC),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               Branch_taken,
  input  logic [WIDTH-1:0]   branchAddr,
  if_prefetch_stage_if.master imem,
  output logic               valid,
  output logic [WIDTH-1:0]   PC,
  output logic [WIDTH-1:0]   Instruction,
`ifdef IF_PREFETCH_PERF_EN
  output logic [31:0]        perf_delivered,
  output logic [31:0]        perf_discarded,
`endif
  output logic [CNT_W-1:0]   count
);

  logic [WIDTH-1:0]   fetch_pc;
  logic [2*WIDTH-1:0] head_entry;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               push;

  assign imem.imem_addr = fetch_pc;
  assign valid          = ~fifo_empty;
  assign PC             = valid ? head_entry[2*WIDTH-1:WIDTH] : '0;
  assign Instruction    = valid ? head_entry[WIDTH-1:0] : WIDTH'(IF_NOP);

  // A branch suppresses both queue operations; the flush is the only effect.
  always_comb begin
    pop  = valid & ~freeze & ~Branch_taken;
    push = imem.imem_ready & ~Branch_taken & (~fifo_full | pop);
  end

  if_prefetch_fifo #(
    .DEPTH (DEPTH),
    .DW    (2 * WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (Branch_taken),
    .push  (push),
    .pop   (pop),
    .wdata ({fetch_pc + WIDTH'(PC_STEP), imem.imem_rdata}),
    .rdata (head_entry),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (Branch_taken) begin
      fetch_pc <= branchAddr;
    end else if (push) begin
      fetch_pc <= fetch_pc + WIDTH'(PC_STEP);
    end
  end

`ifdef IF_PREFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_delivered <= '0;
      perf_discarded <= '0;
    end else begin
      if (pop) begin
        perf_delivered <= perf_delivered + 32'd1;
      end
      if (Branch_taken) begin
        perf_discarded <= perf_discarded + 32'(count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
module tb_if_prefetch_stage;
  import if_prefetch_stage_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        Branch_taken;
  logic [31:0] branchAddr;
  logic        valid;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic [2:0]  count;
`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] perf_delivered;
  logic [31:0] perf_discarded;
`endif

  if_prefetch_stage_if #(.WIDTH(32)) imem_bus ();

  if_prefetch_stage #(
    .WIDTH    (32),
    .DEPTH    (DEPTH),
    .PC_STEP  (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .Branch_taken (Branch_taken),
    .branchAddr   (branchAddr),
    .imem         (imem_bus.master),
    .valid        (valid),
    .PC           (PC),
    .Instruction  (Instruction),
`ifdef IF_PREFETCH_PERF_EN
    .perf_delivered (perf_delivered),
    .perf_discarded (perf_discarded),
`endif
    .count        (count)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: an address-dependent scramble.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  assign imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);

  // Reference model: a plain queue of delivered entries plus the fetch PC.
  if_entry_t   q[$];
  logic [31:0] m_fpc;
  logic [31:0] m_deliv;
  logic [31:0] m_disc;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [2:0]  m_count;

  int unsigned tests;
  int unsigned failed;

  // Drive one cycle of inputs, advance the model at the edge, and settle
  // expected outputs at the following falling edge.
  task automatic step(input logic r, input logic f, input logic b,
                      input logic [31:0] ba, input logic rdy);
    logic   popv;
    logic   pushv;
    rst = r; freeze = f; Branch_taken = b; branchAddr = ba;
    imem_bus.imem_ready = rdy;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_fpc = 32'h0; m_deliv = 0; m_disc = 0;
    end else if (b) begin
      m_disc += 32'(q.size());
      q.delete();
      m_fpc = ba;
    end else begin
      popv  = (q.size() > 0) && !f;
      pushv = rdy && ((q.size() < DEPTH) || popv);
      if (popv) begin
        void'(q.pop_front());
        m_deliv++;
      end
      if (pushv) begin
        q.push_back('{pc: m_fpc + 32'd4, instr: mem_word(m_fpc)});
        m_fpc += 32'd4;
      end
    end
    @(negedge clk);
    m_valid = (q.size() > 0);
    m_pc    = m_valid ? q[0].pc : 32'h0;
    m_instr = m_valid ? q[0].instr : 32'h0;
    m_count = 3'(q.size());
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom, 1'($urandom_range(1)));
      tests++;
      if ({valid, PC, Instruction, count, imem_bus.imem_addr} !== {1'b0, 32'h0, 32'h0, 3'd0, 32'h0}) begin
        failed++;
        $display("FAIL reset[%0d]: got v=%b pc=%h ins=%h cnt=%0d addr=%h, want all 0", i,
                 valid, PC, Instruction, count, imem_bus.imem_addr);
      end
    end
  endtask

  task automatic test_stream();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      tests++;
      if ({valid, PC, Instruction, count, imem_bus.imem_addr} !==
          {m_valid, m_pc, m_instr, m_count, m_fpc} || PC !== 32'(4 * (i + 1)) || count !== 3'd1) begin
        failed++;
        $display("FAIL stream[%0d]: got v=%b pc=%h ins=%h cnt=%0d addr=%h, want v=%b pc=%h ins=%h cnt=%0d addr=%h",
                 i, valid, PC, Instruction, count, imem_bus.imem_addr, m_valid, m_pc, m_instr, m_count, m_fpc);
      end
    end
  endtask

  task automatic test_freeze_fill();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      tests++;
      if ({valid, PC, Instruction, count, imem_bus.imem_addr} !==
          {m_valid, m_pc, m_instr, m_count, m_fpc}) begin
        failed++;
        $display("FAIL freeze_fill[%0d]: got v=%b pc=%h ins=%h cnt=%0d addr=%h, want v=%b pc=%h ins=%h cnt=%0d addr=%h",
                 i, valid, PC, Instruction, count, imem_bus.imem_addr, m_valid, m_pc, m_instr, m_count, m_fpc);
      end
    end
    tests++;
    if (count !== 3'd4 || imem_bus.imem_addr !== 32'h10) begin
      failed++;
      $display("FAIL freeze_full: got cnt=%0d addr=%h, want cnt=4 addr=00000010", count, imem_bus.imem_addr);
    end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (valid !== 1'b1 || PC !== 32'(4 * (i + 1)) || Instruction !== mem_word(32'(4 * i))) begin
        failed++;
        $display("FAIL freeze_release[%0d]: got v=%b pc=%h ins=%h, want v=1 pc=%h ins=%h",
                 i, valid, PC, Instruction, 32'(4 * (i + 1)), mem_word(32'(4 * i)));
      end
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    end
  endtask

  task automatic test_branch();
    logic [31:0] disc0;
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
`ifdef IF_PREFETCH_PERF_EN
    disc0 = perf_discarded;
`else
    disc0 = 32'h0;
`endif
    tests++;
    if (count !== 3'd3) begin
      failed++;
      $display("FAIL branch_pre: got cnt=%0d, want 3", count);
    end
    step(1'b0, 1'b1, 1'b1, 32'h100, 1'b1);
    tests++;
    if (valid !== 1'b0 || count !== 3'd0 || PC !== 32'h0 || imem_bus.imem_addr !== 32'h100) begin
      failed++;
      $display("FAIL branch_flush: got v=%b cnt=%0d pc=%h addr=%h, want v=0 cnt=0 pc=0 addr=00000100",
               valid, count, PC, imem_bus.imem_addr);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tests++;
    if (valid !== 1'b1 || PC !== 32'h104 || Instruction !== mem_word(32'h100)) begin
      failed++;
      $display("FAIL branch_target: got v=%b pc=%h ins=%h, want v=1 pc=00000104 ins=%h",
               valid, PC, Instruction, mem_word(32'h100));
    end
`ifdef IF_PREFETCH_PERF_EN
    tests++;
    if (perf_discarded - disc0 !== 32'd3 || perf_discarded !== m_disc) begin
      failed++;
      $display("FAIL perf_discard: got %0d (delta %0d), want %0d (delta 3)",
               perf_discarded, perf_discarded - disc0, m_disc);
    end
`else
    if (disc0 != 0) $display("note: unexpected discard snapshot");
`endif
  endtask

  task automatic test_full_pushpop();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      tests++;
      if ({valid, PC, Instruction, count, imem_bus.imem_addr} !==
          {m_valid, m_pc, m_instr, m_count, m_fpc} || count !== 3'd4) begin
        failed++;
        $display("FAIL full_pushpop[%0d]: got v=%b pc=%h ins=%h cnt=%0d addr=%h, want v=%b pc=%h ins=%h cnt=4 addr=%h",
                 i, valid, PC, Instruction, count, imem_bus.imem_addr, m_valid, m_pc, m_instr, m_fpc);
      end
    end
  endtask

  task automatic test_ready_toggle();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'(~i[0]));
      tests++;
      if ({valid, PC, Instruction, count, imem_bus.imem_addr} !==
          {m_valid, m_pc, m_instr, m_count, m_fpc}) begin
        failed++;
        $display("FAIL ready_toggle[%0d]: got v=%b pc=%h ins=%h cnt=%0d addr=%h, want v=%b pc=%h ins=%h cnt=%0d addr=%h",
                 i, valid, PC, Instruction, count, imem_bus.imem_addr, m_valid, m_pc, m_instr, m_count, m_fpc);
      end
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      tests++;
      if ({valid, PC, Instruction, count, imem_bus.imem_addr} !==
          {m_valid, m_pc, m_instr, m_count, m_fpc}) begin
        failed++;
        $display("FAIL wrap[%0d]: got v=%b pc=%h ins=%h cnt=%0d addr=%h, want v=%b pc=%h ins=%h cnt=%0d addr=%h",
                 i, valid, PC, Instruction, count, imem_bus.imem_addr, m_valid, m_pc, m_instr, m_count, m_fpc);
      end
    end
    tests++;
    if (imem_bus.imem_addr !== 32'h8) begin
      failed++;
      $display("FAIL wrap_addr: got %h, want 00000008", imem_bus.imem_addr);
    end
  endtask

  task automatic test_reset_vs_branch();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h200, 1'b1);
    tests++;
    if (imem_bus.imem_addr !== 32'h0 || valid !== 1'b0 || count !== 3'd0) begin
      failed++;
      $display("FAIL rst_vs_branch: got addr=%h v=%b cnt=%0d, want addr=0 v=0 cnt=0",
               imem_bus.imem_addr, valid, count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(63) == 0), 1'($urandom_range(2) == 0), 1'($urandom_range(15) == 0),
           $urandom & 32'hFFFF_FFFC, 1'($urandom_range(2) != 0));
      tests++;
      if ({valid, PC, Instruction, count, imem_bus.imem_addr} !==
          {m_valid, m_pc, m_instr, m_count, m_fpc}) begin
        failed++;
        $display("FAIL random[%0d]: got v=%b pc=%h ins=%h cnt=%0d addr=%h, want v=%b pc=%h ins=%h cnt=%0d addr=%h",
                 i, valid, PC, Instruction, count, imem_bus.imem_addr, m_valid, m_pc, m_instr, m_count, m_fpc);
      end
    end
`ifdef IF_PREFETCH_PERF_EN
    tests++;
    if (perf_delivered !== m_deliv || perf_discarded !== m_disc) begin
      failed++;
      $display("FAIL perf_random: got deliv=%0d disc=%0d, want deliv=%0d disc=%0d",
               perf_delivered, perf_discarded, m_deliv, m_disc);
    end
`endif
  endtask

  initial begin
    tests = 0; failed = 0;
    m_fpc = 32'h0; m_deliv = 0; m_disc = 0;
    rst = 1'b1; freeze = 1'b0; Branch_taken = 1'b0; branchAddr = 32'h0;
    imem_bus.imem_ready = 1'b0;
    test_reset();
    test_stream();
    test_freeze_fill();
    test_branch();
    test_full_pushpop();
    test_ready_toggle();
    test_wrap();
    test_reset_vs_branch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
